// File: rtl/seq_ctrl.sv
// Programmable nibble-sequence player: a small pattern memory replayed as a
// valid/ready stream with runtime length, repeat count and abort control.
module seq_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic [7:0]    reps,
  input  logic          abort,
  output logic [3:0]    dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pos
);
  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] pos_q, pos_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    rem_q, rem_d;
  logic          inf_q, inf_d;
  logic [3:0]    dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          start_ok;
  logic          xfer;
  logic          last_sym;
  logic [3:0]    mem0_fwd;

  assign start_ok = (state_q == IDLE) && start && !abort &&
                    (len != '0) && (len <= MAX_LEN);
  assign xfer     = valid_q && dout_ready;
  assign last_sym = ({1'b0, pos_q} == (len_q - 1'b1));
  // A write landing on entry 0 in the start cycle must be visible as the first symbol.
  assign mem0_fwd = (wr_en && (wr_addr == '0)) ? wr_data : mem[0];

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    len_d   = len_q;
    rem_d   = rem_q;
    inf_d   = inf_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          pos_d   = '0;
          len_d   = len;
          rem_d   = reps;
          inf_d   = (reps == 8'd0);
          dout_d  = mem0_fwd;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pos_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (xfer) begin
          if (!last_sym) begin
            pos_d  = pos_q + 1'b1;
            dout_d = mem[pos_q + 1'b1];
          end else if (inf_q || (rem_q > 8'd1)) begin
            pos_d  = '0;
            dout_d = mem[0];
            if (!inf_q) rem_d = rem_q - 8'd1;
          end else begin
            state_d = IDLE;
            pos_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      inf_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      inf_q   <= inf_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Pattern memory survives reset; it is frozen while playing.
  always_ff @(posedge clock) begin
    if (wr_en && (state_q == IDLE)) mem[wr_addr] <= wr_data;
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pos        = pos_q;
endmodule
